// File: rtl/can_pkg.sv
// Shared CAN definitions for the bit-level transmit and receive blocks.
package can_pkg;

  localparam logic CAN_RECESSIVE   = 1'b1;
  localparam int   CAN_STUFF_LIMIT = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_DATA  = 2'd1,
    TX_STUFF = 2'd2
  } can_tx_state_t;

  // System clocks per nominal CAN bit.
  function automatic int can_clks_per_bit(input int clk_mhz, input int rate_kbits);
    return (clk_mhz * 1000) / rate_kbits;
  endfunction

endpackage

// File: rtl/can_bit_timer.sv
// Per-bit counter: runs 0..N-1 while i_run is high, held at 0 otherwise.
// o_bit_end marks the last cycle of each bit period.
module can_bit_timer #(
  parameter int N = 100
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_bit_end
);

  localparam int             W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0]   LAST = W'(N - 1);

  logic [W-1:0] r_cnt;

  // Count within the bit, wrap at the bit end so the next bit starts at 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_run || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_bit_end = i_run && (r_cnt == LAST);

endmodule

// File: rtl/can_tx_bit.sv
// Bit-level CAN transmitter. Drives one accepted bit per nominal bit period
// and, when CAN_TX_BIT_STUFF_EN is defined, inserts a complement stuff bit
// after five equal bits. Line is recessive whenever idle.
module can_tx_bit
  import can_pkg::*;
#(
  parameter int clk_speed_MHz      = 100,
  parameter int can_bit_rate_Kbits = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_din,
  input  logic i_din_valid,
  output logic o_din_ready,
  output logic o_tx,
  output logic o_busy,
  output logic o_bit_start,
  output logic o_stuff_ins,
  output logic o_underrun
);

  localparam int N = can_clks_per_bit(clk_speed_MHz, can_bit_rate_Kbits);

  can_tx_state_t r_state;
  logic          r_tx;
  logic          r_busy;
  logic          r_bit_start;
  logic          r_stuff_ins;
  logic          r_underrun;
  logic          w_bit_end;
  logic          w_stuff_pend;
  logic          w_din_ready;
  logic          w_xfer;

`ifdef CAN_TX_BIT_STUFF_EN
  logic [2:0]    r_run;
  logic          r_last;
  assign w_stuff_pend = (r_run == 3'(CAN_STUFF_LIMIT));
`else
  assign w_stuff_pend = 1'b0;
`endif

  can_bit_timer #(.N(N)) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_run     (r_state != TX_IDLE),
    .o_bit_end (w_bit_end)
  );

  // Handshake: any cycle in idle, otherwise only at a bit end with no stuff due.
  always_comb begin
    w_din_ready = 1'b0;
    if (!i_rst) begin
      case (r_state)
        TX_IDLE: w_din_ready = i_en;
        default: w_din_ready = i_en && w_bit_end && !w_stuff_pend;
      endcase
    end
  end

  assign w_xfer = w_din_ready && i_din_valid;

  // Transmit FSM with registered line and status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= TX_IDLE;
      r_tx        <= CAN_RECESSIVE;
      r_busy      <= 1'b0;
      r_bit_start <= 1'b0;
      r_stuff_ins <= 1'b0;
      r_underrun  <= 1'b0;
`ifdef CAN_TX_BIT_STUFF_EN
      r_run       <= 3'd0;
      r_last      <= CAN_RECESSIVE;
`endif
    end else begin
      r_bit_start <= 1'b0;
      r_stuff_ins <= 1'b0;
      r_underrun  <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (w_xfer) begin
            r_state     <= TX_DATA;
            r_tx        <= i_din;
            r_busy      <= 1'b1;
            r_bit_start <= 1'b1;
`ifdef CAN_TX_BIT_STUFF_EN
            r_run       <= 3'd1;
            r_last      <= i_din;
`endif
          end else begin
            r_tx   <= CAN_RECESSIVE;
            r_busy <= 1'b0;
          end
        end
        default: begin
          if (w_bit_end) begin
`ifdef CAN_TX_BIT_STUFF_EN
            if (w_stuff_pend) begin
              // Stuff bit opens a new run of the complement value.
              r_state     <= TX_STUFF;
              r_tx        <= ~r_last;
              r_last      <= ~r_last;
              r_run       <= 3'd1;
              r_bit_start <= 1'b1;
              r_stuff_ins <= 1'b1;
            end else
`endif
            if (w_xfer) begin
              r_state     <= TX_DATA;
              r_tx        <= i_din;
              r_bit_start <= 1'b1;
`ifdef CAN_TX_BIT_STUFF_EN
              r_run       <= (i_din == r_last) ? (r_run + 3'd1) : 3'd1;
              r_last      <= i_din;
`endif
            end else begin
              r_state    <= TX_IDLE;
              r_tx       <= CAN_RECESSIVE;
              r_busy     <= 1'b0;
              r_underrun <= i_en;
            end
          end
        end
      endcase
    end
  end

  assign o_din_ready = w_din_ready;
  assign o_tx        = r_tx;
  assign o_busy      = r_busy;
  assign o_bit_start = r_bit_start;
  assign o_stuff_ins = r_stuff_ins;
  assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_can_tx_bit.sv
// Directed bench for can_tx_bit at N = 100 clocks per bit.
// Cycle k of a scenario is observed 1 ns after the k-th rising edge following
// the scenario start; cycle 0 is the transfer cycle of the first bit.
module tb_can_tx_bit;

  logic clk = 1'b0;
  logic rst, en, din, din_valid;
  logic din_ready, tx, busy, bit_start, stuff_ins, underrun;

  always #5 clk = ~clk;

  can_tx_bit dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_din       (din),
    .i_din_valid (din_valid),
    .o_din_ready (din_ready),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_bit_start (bit_start),
    .o_stuff_ins (stuff_ins),
    .o_underrun  (underrun)
  );

  // Expected {tx, busy, din_ready, bit_start, stuff_ins, underrun} at a cycle.
  typedef struct {
    int         cyc;
    logic [5:0] exp;
    string      name;
  } chk_t;

  chk_t cps[$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc;
  int sent;
  int n_bs, n_si, n_ur;
  int      s_nb;
  logic [7:0] s_bits;
  bit      s_keep_en;

  function automatic logic [5:0] outs();
    return {tx, busy, din_ready, bit_start, stuff_ins, underrun};
  endfunction

  task automatic check6(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got tx/busy/rdy/bs/si/ur=%b required %b", name, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, exp);
  endtask

  // One clock: record the handshake, advance, then feed the next bit.
  task automatic step();
    bit x;
    @(negedge clk);
    x = din_valid && din_ready;
    @(posedge clk);
    #1;
    cyc++;
    n_bs += int'(bit_start);
    n_si += int'(stuff_ins);
    n_ur += int'(underrun);
    if (x) begin
      sent++;
      if (sent < s_nb) din = s_bits[sent];
      else begin
        din_valid = 1'b0;
        if (!s_keep_en) en = 1'b0;
      end
    end
  endtask

  task automatic add(input int c, input logic [5:0] e, input string n);
    chk_t t;
    t.cyc = c; t.exp = e; t.name = n;
    cps.push_back(t);
  endtask

  // Starts a transmission, walks the checkpoint table, runs to last_cyc.
  task automatic run(input int nb, input logic [7:0] bits, input bit keep_en,
                     input int last_cyc, input int e_bs, input int e_si, input int e_ur,
                     input string tag);
    s_nb = nb; s_bits = bits; s_keep_en = keep_en;
    sent = 0; cyc = 0; n_bs = 0; n_si = 0; n_ur = 0;
    en = 1'b1; din_valid = 1'b1; din = bits[0];
    #1;
    for (int k = 0; k < cps.size(); k++) begin
      while (cyc < cps[k].cyc) step();
      check6({tag, ":", cps[k].name}, outs(), cps[k].exp);
    end
    while (cyc < last_cyc) step();
    check_int({tag, ":bit_start_count"}, n_bs, e_bs);
    check_int({tag, ":stuff_ins_count"}, n_si, e_si);
    check_int({tag, ":underrun_count"},  n_ur, e_ur);
    cps.delete();
    en = 1'b0; din_valid = 1'b0;
  endtask

  task automatic load_scn2();
    add(0,   6'b101000, "c0");
    add(1,   6'b110100, "c1");
    add(2,   6'b110000, "c2");
    add(100, 6'b111000, "c100");
    add(101, 6'b010100, "c101");
    add(150, 6'b010000, "c150");
    add(200, 6'b011000, "c200");
    add(201, 6'b110100, "c201");
    add(300, 6'b110000, "c300");
    add(301, 6'b100000, "c301");
  endtask

  initial begin
    // Scenario 1: reset held with en and din_valid high.
    rst = 1'b1; en = 1'b1; din_valid = 1'b1; din = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check6($sformatf("reset_c%0d", i), outs(), 6'b100000);
    end
    en = 1'b0; din_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check6("idle_after_reset", outs(), 6'b100000);

    // Scenario 2: 1,0,1 back to back; en dropped after the last transfer.
    load_scn2();
    run(3, 8'b0000_0101, 1'b0, 305, 3, 0, 0, "s2");

    // Scenarios 3/4: six zeros.
`ifdef CAN_TX_BIT_STUFF_EN
    add(1,   6'b010100, "c1");
    add(500, 6'b010000, "c500");
    add(501, 6'b110110, "c501");
    add(600, 6'b111000, "c600");
    add(601, 6'b010100, "c601");
    add(700, 6'b010000, "c700");
    add(701, 6'b100000, "c701");
    run(6, 8'b0000_0000, 1'b0, 705, 7, 1, 0, "s3");
`else
    add(1,   6'b010100, "c1");
    add(500, 6'b011000, "c500");
    add(501, 6'b010100, "c501");
    add(600, 6'b010000, "c600");
    add(601, 6'b100000, "c601");
    run(6, 8'b0000_0000, 1'b0, 605, 6, 0, 0, "s4");
`endif

    // Scenario 5: 1,0 then din_valid drops with en held high.
    add(101, 6'b010100, "c101");
    add(200, 6'b011000, "c200");
    add(201, 6'b101001, "c201");
    add(202, 6'b101000, "c202");
    run(2, 8'b0000_0001, 1'b1, 205, 2, 0, 1, "s5");

    // Scenario 6: reset asserted mid-bit while driving 0.
    add(1,  6'b010100, "c1");
    add(50, 6'b010000, "c50");
    s_nb = 1; s_bits = 8'b0; s_keep_en = 1'b1;
    sent = 0; cyc = 0; n_bs = 0; n_si = 0; n_ur = 0;
    en = 1'b1; din_valid = 1'b1; din = 1'b0;
    #1;
    for (int k = 0; k < cps.size(); k++) begin
      while (cyc < cps[k].cyc) step();
      check6({"s6:", cps[k].name}, outs(), cps[k].exp);
    end
    cps.delete();
    din_valid = 1'b1;
    rst = 1'b1;
    #1;
    check6("s6:async_reset", outs(), 6'b100000);
    @(posedge clk); #1;
    check6("s6:reset_hold", outs(), 6'b100000);
    rst = 1'b0; en = 1'b0; din_valid = 1'b0;
    @(posedge clk); #1;
    check6("s6:idle_after_release", outs(), 6'b100000);
    load_scn2();
    run(3, 8'b0000_0101, 1'b0, 305, 3, 0, 0, "s6b");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
